// File: rtl/pipeline_stall_controller_pkg.sv
// Shared state encodings and latch-enable/bubble constants for the pipeline stall controller.
package pipeline_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN      = 2'b00,
    ST_MEM_WAIT = 2'b01,
    ST_FAULT    = 2'b11
  } pipe_state_t;

  localparam logic LE_ON      = 1'b1;
  localparam logic LE_OFF     = 1'b0;
  localparam logic NOP_ACTIVE = 1'b0;
  localparam logic NOP_IDLE   = 1'b1;

endpackage

// File: rtl/pipeline_stall_controller_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_reg;

  always_ff @(posedge clk) begin
    if (clear) begin
      count_reg <= '0;
    end else if (inc && (count_reg != '1)) begin
      count_reg <= count_reg + WIDTH'(1);
    end
  end

  assign count = count_reg;

endmodule

// File: rtl/pipeline_stall_controller.sv
// Pipeline latch-enable / bubble / flush sequencer with data-memory timeout detection.
// Optional performance counters are built only when PERF_COUNTERS_EN is defined.
module pipeline_stall_controller
  import pipeline_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_use_stall,
  input  logic             branch_taken_ex,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             LE_PC,
  output logic             LE_IF_ID,
  output logic             LE_ID_EX,
  output logic             LE_EX_MEM,
  output logic             LE_MEM_WB,
  output logic             NOP_ID_EX,
  output logic             NOP_MEM_WB,
  output logic             flush_IF_ID,
  output logic             mem_fault,
  output logic [1:0]       state_o,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count
);

  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

  pipe_state_t       state_reg, state_next;
  logic [WAIT_W-1:0] wait_cnt_reg, wait_cnt_next;
  logic              mem_fault_reg, mem_fault_next;
  logic              hold_mem;
  logic              run_eval;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= ST_RUN;
      wait_cnt_reg  <= '0;
      mem_fault_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      wait_cnt_reg  <= wait_cnt_next;
      mem_fault_reg <= mem_fault_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    wait_cnt_next  = wait_cnt_reg;
    mem_fault_next = mem_fault_reg;
    hold_mem       = 1'b0;
    run_eval       = 1'b0;
    LE_PC          = LE_ON;
    LE_IF_ID       = LE_ON;
    LE_ID_EX       = LE_ON;
    LE_EX_MEM      = LE_ON;
    LE_MEM_WB      = LE_ON;
    NOP_ID_EX      = NOP_IDLE;
    NOP_MEM_WB     = NOP_IDLE;
    flush_IF_ID    = 1'b0;

    if (!reset) begin
      case (state_reg)
        ST_RUN: begin
          if (mem_req && !mem_ready) begin
            hold_mem      = 1'b1;
            state_next    = ST_MEM_WAIT;
            wait_cnt_next = WAIT_W'(1);
          end else begin
            run_eval = 1'b1;
          end
        end
        ST_MEM_WAIT: begin
          if (mem_ready) begin
            run_eval      = 1'b1;
            state_next    = ST_RUN;
            wait_cnt_next = '0;
          end else begin
            hold_mem = 1'b1;
            if (wait_cnt_reg == WAIT_W'(MEM_TIMEOUT)) begin
              state_next     = ST_FAULT;
              mem_fault_next = 1'b1;
            end else begin
              wait_cnt_next = wait_cnt_reg + WAIT_W'(1);
            end
          end
        end
        ST_FAULT: begin
          LE_PC     = LE_OFF;
          LE_IF_ID  = LE_OFF;
          LE_ID_EX  = LE_OFF;
          LE_EX_MEM = LE_OFF;
          LE_MEM_WB = LE_OFF;
        end
        default: state_next = ST_RUN;
      endcase
    end

    // Memory wait freezes everything upstream of WB and drains a bubble into WB.
    if (hold_mem) begin
      LE_PC      = LE_OFF;
      LE_IF_ID   = LE_OFF;
      LE_ID_EX   = LE_OFF;
      LE_EX_MEM  = LE_OFF;
      NOP_MEM_WB = NOP_ACTIVE;
    end

    // A taken branch squashes the stalled instruction, so it wins over load-use.
    if (run_eval) begin
      if (branch_taken_ex) begin
        flush_IF_ID = 1'b1;
        NOP_ID_EX   = NOP_ACTIVE;
      end else if (load_use_stall) begin
        LE_PC     = LE_OFF;
        LE_IF_ID  = LE_OFF;
        NOP_ID_EX = NOP_ACTIVE;
      end
    end
  end

  assign mem_fault = mem_fault_reg;
  assign state_o   = state_reg;

`ifdef PERF_COUNTERS_EN
  logic [1:0]       cnt_inc;
  logic [CNT_W-1:0] cnt_val [2];

  assign cnt_inc[0] = !reset && (LE_PC == LE_OFF);
  assign cnt_inc[1] = !reset && flush_IF_ID;

  for (genvar gi = 0; gi < 2; gi++) begin : g_perf
    sat_counter #(.WIDTH(CNT_W)) u_cnt (
      .clk   (clk),
      .clear (reset),
      .inc   (cnt_inc[gi]),
      .count (cnt_val[gi])
    );
  end

  assign stall_cycles = cnt_val[0];
  assign flush_count  = cnt_val[1];
`else
  assign stall_cycles = '0;
  assign flush_count  = '0;
`endif

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// Directed self-checking bench for pipeline_stall_controller (MEM_TIMEOUT=4).
module tb_pipeline_stall_controller;

  localparam int CNT_W = 16;
`ifdef PERF_COUNTERS_EN
  localparam int PERF = 1;
`else
  localparam int PERF = 0;
`endif

  logic             clk = 1'b0;
  logic             reset;
  logic             load_use_stall, branch_taken_ex, mem_req, mem_ready;
  logic             LE_PC, LE_IF_ID, LE_ID_EX, LE_EX_MEM, LE_MEM_WB;
  logic             NOP_ID_EX, NOP_MEM_WB, flush_IF_ID, mem_fault;
  logic [1:0]       state_o;
  logic [CNT_W-1:0] stall_cycles, flush_count;

  int errors = 0;
  int checks = 0;

  pipeline_stall_controller #(.MEM_TIMEOUT(4), .CNT_W(CNT_W)) dut (
    .clk             (clk),
    .reset           (reset),
    .load_use_stall  (load_use_stall),
    .branch_taken_ex (branch_taken_ex),
    .mem_req         (mem_req),
    .mem_ready       (mem_ready),
    .LE_PC           (LE_PC),
    .LE_IF_ID        (LE_IF_ID),
    .LE_ID_EX        (LE_ID_EX),
    .LE_EX_MEM       (LE_EX_MEM),
    .LE_MEM_WB       (LE_MEM_WB),
    .NOP_ID_EX       (NOP_ID_EX),
    .NOP_MEM_WB      (NOP_MEM_WB),
    .flush_IF_ID     (flush_IF_ID),
    .mem_fault       (mem_fault),
    .state_o         (state_o),
    .stall_cycles    (stall_cycles),
    .flush_count     (flush_count)
  );

  always #5 clk = ~clk;

  wire [4:0] le_all  = {LE_PC, LE_IF_ID, LE_ID_EX, LE_EX_MEM, LE_MEM_WB};
  wire [1:0] nop_all = {NOP_ID_EX, NOP_MEM_WB};

  // Inputs change 1ns after the edge; outputs are sampled 4ns later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #4;
  endtask

  task automatic test_reset();
    reset = 1'b1; load_use_stall = 1'b0; branch_taken_ex = 1'b0; mem_req = 1'b0; mem_ready = 1'b0;
    step(); step();
    load_use_stall = 1'b1;
    settle();
    checks++; if (le_all !== 5'b11111) begin errors++; $display("FAIL reset_le_in_reset: got %b expected %b", le_all, 5'b11111); end
    checks++; if (nop_all !== 2'b11) begin errors++; $display("FAIL reset_nop_in_reset: got %b expected %b", nop_all, 2'b11); end
    load_use_stall = 1'b0;
    step();
    reset = 1'b0;
    settle();
    checks++; if (le_all !== 5'b11111) begin errors++; $display("FAIL reset_le: got %b expected %b", le_all, 5'b11111); end
    checks++; if (nop_all !== 2'b11 || flush_IF_ID !== 1'b0) begin errors++; $display("FAIL reset_nop_flush: got %b/%b expected 11/0", nop_all, flush_IF_ID); end
    checks++; if (state_o !== 2'b00 || mem_fault !== 1'b0) begin errors++; $display("FAIL reset_state: got %b/%b expected 00/0", state_o, mem_fault); end
    checks++; if (stall_cycles !== '0 || flush_count !== '0) begin errors++; $display("FAIL reset_counters: got %0d/%0d expected 0/0", stall_cycles, flush_count); end
    $display("test_reset done");
  endtask

  task automatic test_load_use();
    step();
    load_use_stall = 1'b1;
    settle();
    checks++; if (le_all !== 5'b00111) begin errors++; $display("FAIL load_use_le: got %b expected %b", le_all, 5'b00111); end
    checks++; if (nop_all !== 2'b01) begin errors++; $display("FAIL load_use_nop: got %b expected %b", nop_all, 2'b01); end
    step();
    load_use_stall = 1'b0;
    settle();
    checks++; if (le_all !== 5'b11111) begin errors++; $display("FAIL load_use_release: got %b expected %b", le_all, 5'b11111); end
    checks++; if (stall_cycles !== CNT_W'(PERF * 1)) begin errors++; $display("FAIL load_use_stall_cnt: got %0d expected %0d", stall_cycles, PERF * 1); end
    $display("test_load_use done");
  endtask

  task automatic test_branch();
    step();
    branch_taken_ex = 1'b1; load_use_stall = 1'b1;
    settle();
    checks++; if (flush_IF_ID !== 1'b1 || NOP_ID_EX !== 1'b0) begin errors++; $display("FAIL branch_flush: got %b/%b expected 1/0", flush_IF_ID, NOP_ID_EX); end
    checks++; if (le_all !== 5'b11111) begin errors++; $display("FAIL branch_le: got %b expected %b", le_all, 5'b11111); end
    step();
    branch_taken_ex = 1'b0; load_use_stall = 1'b0;
    settle();
    checks++; if (flush_IF_ID !== 1'b0 || flush_count !== CNT_W'(PERF * 1)) begin errors++; $display("FAIL branch_count: got %b/%0d expected 0/%0d", flush_IF_ID, flush_count, PERF); end
    $display("test_branch done");
  endtask

  task automatic test_mem_wait();
    step();
    mem_req = 1'b1; mem_ready = 1'b0;
    settle();
    checks++; if (state_o !== 2'b00 || le_all !== 5'b00001 || NOP_MEM_WB !== 1'b0) begin errors++; $display("FAIL mem_first: got st=%b le=%b nop=%b expected 00/00001/0", state_o, le_all, NOP_MEM_WB); end
    for (int i = 0; i < 2; i++) begin
      step();
      settle();
      checks++; if (state_o !== 2'b01 || le_all !== 5'b00001 || NOP_MEM_WB !== 1'b0) begin errors++; $display("FAIL mem_wait%0d: got st=%b le=%b nop=%b expected 01/00001/0", i, state_o, le_all, NOP_MEM_WB); end
    end
    step();
    mem_ready = 1'b1;
    settle();
    checks++; if (le_all !== 5'b11111 || nop_all !== 2'b11) begin errors++; $display("FAIL mem_ready_le: got %b/%b expected 11111/11", le_all, nop_all); end
    step();
    mem_req = 1'b1; mem_ready = 1'b1;
    settle();
    checks++; if (state_o !== 2'b00 || stall_cycles !== CNT_W'(PERF * 4)) begin errors++; $display("FAIL mem_done: got st=%b stall=%0d expected 00/%0d", state_o, stall_cycles, PERF * 4); end
    checks++; if (le_all !== 5'b11111) begin errors++; $display("FAIL mem_zero_wait_le: got %b expected %b", le_all, 5'b11111); end
    step();
    mem_req = 1'b0; mem_ready = 1'b0;
    settle();
    checks++; if (state_o !== 2'b00 || stall_cycles !== CNT_W'(PERF * 4)) begin errors++; $display("FAIL mem_zero_wait_cnt: got st=%b stall=%0d expected 00/%0d", state_o, stall_cycles, PERF * 4); end
    $display("test_mem_wait done");
  endtask

  task automatic test_branch_on_ready();
    step();
    mem_req = 1'b1; mem_ready = 1'b0; branch_taken_ex = 1'b1;
    settle();
    checks++; if (flush_IF_ID !== 1'b0 || LE_PC !== 1'b0) begin errors++; $display("FAIL bor_wait_flush: got %b/%b expected 0/0", flush_IF_ID, LE_PC); end
    step();
    mem_ready = 1'b1;
    settle();
    checks++; if (flush_IF_ID !== 1'b1 || NOP_ID_EX !== 1'b0 || LE_PC !== 1'b1) begin errors++; $display("FAIL bor_ready_flush: got %b/%b/%b expected 1/0/1", flush_IF_ID, NOP_ID_EX, LE_PC); end
    step();
    mem_req = 1'b0; mem_ready = 1'b0; branch_taken_ex = 1'b0;
    settle();
    checks++; if (state_o !== 2'b00 || flush_IF_ID !== 1'b0) begin errors++; $display("FAIL bor_after: got %b/%b expected 00/0", state_o, flush_IF_ID); end
    checks++; if (flush_count !== CNT_W'(PERF * 2) || stall_cycles !== CNT_W'(PERF * 5)) begin errors++; $display("FAIL bor_counters: got %0d/%0d expected %0d/%0d", flush_count, stall_cycles, PERF * 2, PERF * 5); end
    $display("test_branch_on_ready done");
  endtask

  task automatic test_timeout();
    step();
    mem_req = 1'b1; mem_ready = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      step();
      settle();
      checks++; if (state_o !== 2'b01 || mem_fault !== 1'b0) begin errors++; $display("FAIL timeout_wait%0d: got %b/%b expected 01/0", i, state_o, mem_fault); end
    end
    step();
    settle();
    checks++; if (state_o !== 2'b11 || mem_fault !== 1'b1) begin errors++; $display("FAIL timeout_fault: got %b/%b expected 11/1", state_o, mem_fault); end
    checks++; if (le_all !== 5'b00000 || nop_all !== 2'b11 || flush_IF_ID !== 1'b0) begin errors++; $display("FAIL timeout_frozen: got %b/%b/%b expected 00000/11/0", le_all, nop_all, flush_IF_ID); end
    step();
    mem_req = 1'b0; mem_ready = 1'b1; branch_taken_ex = 1'b1;
    settle();
    checks++; if (state_o !== 2'b11 || mem_fault !== 1'b1 || le_all !== 5'b00000 || flush_IF_ID !== 1'b0) begin errors++; $display("FAIL fault_sticky: got st=%b f=%b le=%b fl=%b expected 11/1/00000/0", state_o, mem_fault, le_all, flush_IF_ID); end
    checks++; if (stall_cycles !== CNT_W'(PERF * 11)) begin errors++; $display("FAIL fault_stall_cnt: got %0d expected %0d", stall_cycles, PERF * 11); end
    reset = 1'b1; mem_ready = 1'b0; branch_taken_ex = 1'b0;
    step();
    reset = 1'b0;
    settle();
    checks++; if (state_o !== 2'b00 || mem_fault !== 1'b0 || le_all !== 5'b11111) begin errors++; $display("FAIL fault_reset: got st=%b f=%b le=%b expected 00/0/11111", state_o, mem_fault, le_all); end
    checks++; if (stall_cycles !== '0 || flush_count !== '0) begin errors++; $display("FAIL fault_reset_cnt: got %0d/%0d expected 0/0", stall_cycles, flush_count); end
    $display("test_timeout done");
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_branch();
    test_mem_wait();
    test_branch_on_ready();
    test_timeout();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pipeline_stall_controller.md
Name: pipeline_stall_controller

Overview:
Central sequencer for the 5-stage pipeline's latch enables and bubble/flush controls (PC, IF/ID, ID/EX, EX/MEM, MEM/WB). It combines three inputs: the hazard-forwarding unit's load-use stall request, branch-taken resolution from EX, and the data-memory handshake for multi-cycle accesses. It drives every pipeline register enable from one FSM and detects memory timeouts.

Parameters:
MEM_TIMEOUT, 15, max consecutive wait cycles tolerated on a data-memory access before fault (1..255)
CNT_W, 16, width of performance counters

Ports:
clk  input  1  pipeline clock, rising edge
reset  input  1  synchronous, active-high reset
load_use_stall  input  1  load-use hazard from hazard-forwarding unit (active-high; inverse of its NOP)
branch_taken_ex  input  1  branch in EX resolved taken; PC loads target this cycle
mem_req  input  1  MEM stage instruction accesses data memory
mem_ready  input  1  data memory completes access this cycle
LE_PC  output  1  PC load enable
LE_IF_ID  output  1  IF/ID load enable
LE_ID_EX  output  1  ID/EX load enable
LE_EX_MEM  output  1  EX/MEM load enable
LE_MEM_WB  output  1  MEM/WB load enable
NOP_ID_EX  output  1  active-low: 0 loads bubble into ID/EX control
NOP_MEM_WB  output  1  active-low: 0 loads bubble into MEM/WB control
flush_IF_ID  output  1  clears IF/ID instruction to NOP
mem_fault  output  1  sticky timeout flag
state_o  output  2  current FSM state (debug)
stall_cycles  output  CNT_W  cycles with LE_PC=0
flush_count  output  CNT_W  number of branch flushes

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-high.
- Reset: state=RUN, wait_cnt=0, mem_fault=0, counters=0.
  - While reset is high: all LE_*=1, NOP_*=1, flush_IF_ID=0.
- Timing model:
  - Control outputs are combinational (Mealy) from the registered state and current inputs.
  - State, wait_cnt and counters update on the rising edge of clk.
- States: RUN=2'b00, MEM_WAIT=2'b01, FAULT=2'b11.
- RUN, evaluated in priority order:
  1. mem_req && !mem_ready:
     - all LE_* = 0, except LE_MEM_WB=1 with NOP_MEM_WB=0 (bubble into WB).
     - next state = MEM_WAIT, wait_cnt <= 1.
     - branch_taken_ex and load_use_stall are ignored this cycle; they are held in frozen registers and re-evaluated later.
  2. branch_taken_ex:
     - all LE_*=1, flush_IF_ID=1, NOP_ID_EX=0.
     - load_use_stall is ignored, because the stalled instruction is being squashed.
  3. load_use_stall:
     - LE_PC=0, LE_IF_ID=0, NOP_ID_EX=0.
     - other LE_*=1; stays in RUN.
  4. Otherwise: all LE_*=1, NOP_*=1, flush_IF_ID=0.
- MEM_WAIT:
  - Outputs are the same as RUN rule 1.
  - mem_ready=1: the same cycle applies RUN-rule evaluation with the memory condition treated as satisfied (all stages advance, or branch/load-use rule applies); next state = RUN, wait_cnt <= 0.
  - mem_ready=0 and wait_cnt == MEM_TIMEOUT: next state = FAULT, mem_fault <= 1.
  - Otherwise wait_cnt <= wait_cnt + 1.
- FAULT:
  - All LE_*=0, NOP_*=1, flush_IF_ID=0; the pipeline is frozen.
  - Exit is by reset only; mem_fault stays 1.
- mem_ready=1 with mem_req=0 is ignored.
- wait_cnt width is clog2(MEM_TIMEOUT+1). It never wraps, because FAULT is entered first.
- A mem_req access completing on the first cycle (mem_ready=1) costs zero stall cycles.

Optional Feature:
PERF_COUNTERS_EN
- Defined:
  - stall_cycles increments every non-reset cycle with LE_PC=0 (includes FAULT).
  - flush_count increments on each cycle with flush_IF_ID=1.
  - Both saturate at all-ones; no wrap.
- Undefined: stall_cycles and flush_count are tied to 0 and no counter flops are generated.

Decomposition:
- Shared package pipeline_ctrl_pkg:
  - state encodings ST_RUN, ST_MEM_WAIT, ST_FAULT (2-bit typedef pipe_state_t).
  - constants LE_ON/LE_OFF and NOP_ACTIVE=1'b0, NOP_IDLE=1'b1.
- One natural sub-module: sat_counter (parameterised width, inc, clear), instantiated twice under PERF_COUNTERS_EN.

Test Plan:
- Reset held 2 cycles, then released with all inputs 0 -> all LE_*=1, NOP_*=1, state_o=00, counters=0.
- load_use_stall=1 for 1 cycle -> LE_PC=0, LE_IF_ID=0, NOP_ID_EX=0, LE_EX_MEM=1; next cycle all LE=1; stall_cycles=1.
- branch_taken_ex=1 and load_use_stall=1 in the same cycle -> flush_IF_ID=1, NOP_ID_EX=0, LE_PC=1; flush_count=1.
- mem_req=1, mem_ready low for 3 cycles then high:
  - wait cycles: state_o=01, LE_PC..LE_EX_MEM=0, NOP_MEM_WB=0.
  - ready cycle: all LE=1; state_o returns to 00; stall_cycles=3.
- mem_req=1 in MEM_WAIT with branch_taken_ex=1 arriving on the ready cycle -> flush_IF_ID=1 on the ready cycle only.
- MEM_TIMEOUT=4, mem_ready never asserted:
  - after 4 wait cycles: state_o=11, mem_fault=1, all LE=0.
  - fault persists; reset clears it to RUN.
